gpio: RTL and testbench
=======================

# gpio

Memory-mapped general-purpose I/O peripheral on the system bus, decoded on chip-enable slot BUS_CE[4] next to the external timer. It drives WIDTH output pins and samples WIDTH input pins through a two-flop synchronizer. Rising edges on the inputs set sticky pending bits, and those bits raise a level interrupt to a core machine-external-interrupt input. It answers the core's CE/REQ/GNT bus handshake with a single-cycle grant, and read data is valid while the grant is high.

## Interface
- WIDTH, 8: number of GPIO pins, 1..32; register bits at index WIDTH and above read 0 and ignore writes
- i_CLK  in  1  system clock; every flop is rising-edge
- i_RST  in  1  synchronous, active-high reset
- i_CE  in  1  chip enable from bus decode (BUS_CE[4])
- i_REQ  in  1  bus request; an access starts when i_CE & i_REQ
- i_WE  in  1  1 = write, 0 = read
- i_HB  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word
- i_ADDR  in  32  byte address; [3:2] selects the register, [1:0] selects the lane
- i_WDATA  in  32  write data, already lane-aligned by the core
- o_RDATA  out  32  read data; valid while o_GNT=1, 0 otherwise
- o_GNT  out  1  one-cycle access grant
- o_IRQ  out  1  level interrupt = |(PEND & IEN)
- i_GPIO  in  WIDTH  asynchronous input pins
- o_GPIO  out  WIDTH  output pins = OUT register

## Operation
- Register map, selected by ADDR[3:2]:
  - 0 OUT: read/write.
  - 1 IN: read-only, returns the synchronized inputs; writes are ignored.
  - 2 IEN: read/write, per-pin rising-edge interrupt enable.
  - 3 PEND: read, or write-1-to-clear.
- Write lane masking:
  - Byte writes update byte ADDR[1:0] only.
  - Halfword writes update half ADDR[1] only.
  - Word writes update all bytes.
  - PEND follows the same masking: only 1s inside the selected lanes clear bits.
- Input path:
  - sync1 <= i_GPIO, then sync2 <= sync1, then prev <= sync2.
  - IN reads sync2.
  - edge = sync2 & ~prev.
- Pending update, every cycle: PEND <= (PEND & ~clr) | (edge & IEN).
  - Set wins over a simultaneous clear of the same bit.
  - Edges on pins with IEN=0 are not recorded.
  - Clearing IEN does not clear PEND, but it masks o_IRQ.
- Bus FSM has two states:
  - IDLE: if i_CE & i_REQ, go to ACK. A write commits at this edge. For a read, the selected register is sampled into the read register at this edge.
  - ACK: o_GNT=1 and o_RDATA = the sampled value (0 for writes). Always return to IDLE. CE/REQ are ignored in ACK, so back-to-back requests are granted every second cycle.
- Read data is always the full 32-bit register. The core extracts the lane using i_HB and i_ADDR[1:0].
- Reset:
  - OUT, IEN, PEND, sync1, sync2 and prev are all 0; FSM is IDLE.
  - o_GNT=0, o_RDATA=0, o_IRQ=0, o_GPIO=0.
  - Reset asserted mid-access aborts it: no grant is issued and no write commits on that edge.

## Timing
- Access latency: request seen at edge N; o_GNT is high for exactly the cycle after edge N; o_GNT falls at edge N+1.
- Write visibility: the new OUT value appears on o_GPIO in the same cycle o_GNT is high.
- Pin-to-IN latency: a pin change is visible in IN 2 edges later.
- Pin-to-PEND latency: PEND sets 3 edges after the pin change.
- Interrupt latency: o_IRQ rises in the same cycle PEND sets (combinational from PEND & IEN).
- A PEND read returns the value captured at edge N. An edge that lands at edge N is therefore visible in that read.
- A W1C write at edge N lowers o_IRQ in the grant cycle, unless the same bit is set again at edge N.

## Test plan
- Reset values: hold i_RST for 3 cycles -> o_GPIO=0, o_IRQ=0, o_GNT=0, o_RDATA=0; a word read of every register returns 0x00000000.
- Write/readback with lanes:
  - word write OUT=0xA5 -> o_GPIO=0xA5 in the grant cycle.
  - byte write to ADDR 0x1 with WDATA 0x0000FF00 -> OUT is unchanged (WIDTH=8).
  - word write IN=0xFF -> read IN still returns the pins.
- Handshake: CE&REQ held high for 6 cycles -> o_GNT pattern 0,1,0,1,0,1; exactly 3 accesses commit.
- Edge interrupt:
  - IEN=0x01; i_GPIO[0] 0->1 -> PEND=0x01 and o_IRQ=1 three edges later.
  - i_GPIO[1] rising with IEN[1]=0 -> PEND[1] stays 0.
  - W1C write PEND=0x01 -> o_IRQ=0 in the grant cycle.
- Simultaneous set/clear: a W1C of bit 0 committed on the same edge as a new bit-0 edge -> PEND[0] stays 1 and o_IRQ stays 1.
- Reset mid-access: assert i_RST on the edge a write OUT=0x3C is requested -> no grant, OUT=0 afterwards, FSM in IDLE.

Source files
------------

// File: rtl/gpio.sv
// Memory-mapped GPIO: OUT/IN/IEN/PEND registers behind a CE/REQ/GNT handshake,
// two-flop input synchronizer, sticky rising-edge pending bits and a level IRQ.
//
// state | meaning
// IDLE  | waiting for CE & REQ; an access commits on the edge leaving IDLE
// ACK   | grant cycle; read data presented, new requests ignored
module gpio #(
  parameter int WIDTH = 8
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_CE,
  input  logic             i_REQ,
  input  logic             i_WE,
  input  logic [1:0]       i_HB,
  input  logic [31:0]      i_ADDR,
  input  logic [31:0]      i_WDATA,
  output logic [31:0]      o_RDATA,
  output logic             o_GNT,
  output logic             o_IRQ,
  input  logic [WIDTH-1:0] i_GPIO,
  output logic [WIDTH-1:0] o_GPIO
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t state_q, state_d;
  logic   access;

  logic [WIDTH-1:0] out_q, ien_q, pend_q, pend_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] rise, clr, wr_mask, wr_bits;
  logic [31:0]      lane_mask, rd_sel, rdata_q;
  logic             we_out, we_ien, we_pend;
  logic             unused_bits;

  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_CE && i_REQ) begin
          access  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lane_mask = '1;
    case (i_HB)
      2'b00:   lane_mask = 32'h0000_00FF << {i_ADDR[1:0], 3'b000};
      2'b01:   lane_mask = i_ADDR[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: lane_mask = '1;
    endcase
  end

  assign wr_mask = lane_mask[WIDTH-1:0];
  assign wr_bits = i_WDATA[WIDTH-1:0];
  assign we_out  = access && i_WE && (i_ADDR[3:2] == 2'd0);
  assign we_ien  = access && i_WE && (i_ADDR[3:2] == 2'd2);
  assign we_pend = access && i_WE && (i_ADDR[3:2] == 2'd3);

  // Set has priority over a same-cycle write-1-to-clear of the same bit.
  assign rise   = sync2_q & ~prev_q;
  assign clr    = we_pend ? (wr_bits & wr_mask) : '0;
  assign pend_d = (pend_q & ~clr) | (rise & ien_q);

  // PEND reads return the post-edge value so an edge landing on the access edge is seen.
  always_comb begin
    rd_sel = '0;
    case (i_ADDR[3:2])
      2'd0:    rd_sel[WIDTH-1:0] = out_q;
      2'd1:    rd_sel[WIDTH-1:0] = sync2_q;
      2'd2:    rd_sel[WIDTH-1:0] = ien_q;
      default: rd_sel[WIDTH-1:0] = pend_d;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      out_q   <= '0;
      ien_q   <= '0;
      pend_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
    end else begin
      sync1_q <= i_GPIO;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
      if (we_out) out_q <= (out_q & ~wr_mask) | (wr_bits & wr_mask);
      if (we_ien) ien_q <= (ien_q & ~wr_mask) | (wr_bits & wr_mask);
      rdata_q <= (access && !i_WE) ? rd_sel : '0;
    end
  end

  assign o_GNT   = (state_q == S_ACK);
  assign o_RDATA = o_GNT ? rdata_q : '0;
  assign o_IRQ   = |(pend_q & ien_q);
  assign o_GPIO  = out_q;

  assign unused_bits = ^{i_ADDR[31:4], i_WDATA, lane_mask};

endmodule

// File: tb/tb_gpio.sv
// Directed bench for gpio: behavioural model compared every cycle, plus literal checks.
module tb_gpio;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst, ce, req, we;
  logic [1:0]    hb;
  logic [31:0]   addr, wdata, rdata;
  logic          gnt, irq;
  logic [W-1:0]  gpio_in, gpio_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio #(.WIDTH(W)) dut (
    .i_CLK(clk), .i_RST(rst), .i_CE(ce), .i_REQ(req), .i_WE(we), .i_HB(hb),
    .i_ADDR(addr), .i_WDATA(wdata), .o_RDATA(rdata), .o_GNT(gnt), .o_IRQ(irq),
    .i_GPIO(gpio_in), .o_GPIO(gpio_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register contents plus a history of pin samples, one entry per edge.
  logic [W-1:0] m_out, m_ien, m_pend;
  logic [W-1:0] seen [3];
  logic         m_gnt;
  logic [31:0]  m_rdata;
  bit           live = 0;

  always @(posedge clk) begin : model
    logic [W-1:0] in_val, rise, clr, wm;
    logic [31:0]  bmask, nrd;
    logic         ngnt, en;
    if (rst) begin
      m_out = '0; m_ien = '0; m_pend = '0; m_gnt = 0; m_rdata = '0;
      for (int i = 0; i < 3; i++) seen[i] = '0;
      live = 1;
    end else begin
      in_val = seen[1];
      rise   = seen[1] & ~seen[2] & m_ien;
      clr    = '0;
      ngnt   = 0;
      nrd    = '0;
      if (!m_gnt && ce && req) begin
        ngnt = 1;
        for (int b = 0; b < 4; b++) begin
          if (hb == 2'b00)      en = (b == int'(addr[1:0]));
          else if (hb == 2'b01) en = ((b / 2) == int'(addr[1]));
          else                  en = 1'b1;
          bmask[8*b +: 8] = en ? 8'hFF : 8'h00;
        end
        wm = bmask[W-1:0];
        if (we) begin
          case (addr[3:2])
            2'd0: m_out = (m_out & ~wm) | (wdata[W-1:0] & wm);
            2'd2: m_ien = (m_ien & ~wm) | (wdata[W-1:0] & wm);
            2'd3: clr = wdata[W-1:0] & wm;
            default: ;
          endcase
        end
      end
      m_pend = (m_pend & ~clr) | rise;
      if (ngnt && !we) begin
        case (addr[3:2])
          2'd0: nrd = 32'(m_out);
          2'd1: nrd = 32'(in_val);
          2'd2: nrd = 32'(m_ien);
          default: nrd = 32'(m_pend);
        endcase
      end
      m_gnt   = ngnt;
      m_rdata = nrd;
      seen[2] = seen[1];
      seen[1] = seen[0];
      seen[0] = gpio_in;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_gpio",  32'(gpio_out), 32'(m_out));
      chk("model_irq",   32'(irq),      32'(|(m_pend & m_ien)));
      chk("model_gnt",   32'(gnt),      32'(m_gnt));
      chk("model_rdata", rdata,         m_gnt ? m_rdata : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the grant cycle.
  task automatic bus(input logic w, input logic [1:0] size, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic [W-1:0] g, output logic ir);
    ce = 1; req = 1; we = w; hb = size; addr = a; wdata = d;
    tick();
    ce = 0; req = 0;
    @(negedge clk);
    rd = rdata; g = gpio_out; ir = irq;
    chk("bus_gnt", 32'(gnt), 32'd1);
    tick();
  endtask

  logic [31:0]  rd;
  logic [W-1:0] g;
  logic         ir;
  logic [5:0]   gnt_pat;

  initial begin
    rst = 1; ce = 0; req = 0; we = 0; hb = 2'b10; addr = '0; wdata = '0; gpio_in = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_gpio", 32'(gpio_out), 32'h0);
    chk("rst_irq",  32'(irq),      32'h0);
    chk("rst_gnt",  32'(gnt),      32'h0);
    chk("rst_rdata", rdata,        32'h0);
    rst = 0;
    tick();
    for (int r = 0; r < 4; r++) begin
      bus(0, 2'b10, 32'(r * 4), 32'h0, rd, g, ir);
      chk("rst_read", rd, 32'h0);
    end

    bus(1, 2'b10, 32'h0, 32'h0000_00A5, rd, g, ir);
    chk("out_word_gnt", 32'(g), 32'hA5);
    bus(1, 2'b00, 32'h1, 32'h0000_FF00, rd, g, ir);
    bus(1, 2'b01, 32'h2, 32'h1234_0000, rd, g, ir);
    bus(0, 2'b10, 32'h0, 32'h0, rd, g, ir);
    chk("out_lane_miss", rd, 32'hA5);
    bus(1, 2'b00, 32'h0, 32'h0000_003C, rd, g, ir);
    chk("out_byte0", 32'(g), 32'h3C);

    gpio_in = 8'h5A;
    repeat (3) tick();
    bus(1, 2'b10, 32'h4, 32'h0000_00FF, rd, g, ir);
    bus(0, 2'b10, 32'h4, 32'h0, rd, g, ir);
    chk("in_readonly", rd, 32'h5A);

    ce = 1; req = 1; we = 1; hb = 2'b10; addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      wdata = 32'(i + 1);
      @(negedge clk);
      gnt_pat[i] = gnt;
      tick();
    end
    ce = 0; req = 0;
    chk("hs_pattern", 32'(gnt_pat), 32'h2A);
    @(negedge clk);
    chk("hs_idle", 32'(gnt), 32'h0);
    tick();
    bus(0, 2'b10, 32'h0, 32'h0, rd, g, ir);
    chk("hs_commits", rd, 32'h05);

    gpio_in = 8'h00;
    repeat (4) tick();
    bus(1, 2'b10, 32'h8, 32'h0000_0001, rd, g, ir);
    gpio_in = 8'h01;
    tick(); tick();
    @(negedge clk);
    chk("irq_early", 32'(irq), 32'h0);
    tick();
    @(negedge clk);
    chk("irq_third_edge", 32'(irq), 32'h1);
    tick();
    gpio_in = 8'h03;
    repeat (4) tick();
    bus(0, 2'b10, 32'hC, 32'h0, rd, g, ir);
    chk("pend_masked", rd, 32'h01);
    bus(1, 2'b10, 32'hC, 32'h0000_0001, rd, g, ir);
    chk("w1c_irq", 32'(ir), 32'h0);

    gpio_in = 8'h02; repeat (4) tick();
    gpio_in = 8'h03; repeat (4) tick();
    gpio_in = 8'h02; repeat (4) tick();
    gpio_in = 8'h03;
    tick(); tick();
    bus(1, 2'b10, 32'hC, 32'h0000_0001, rd, g, ir);
    chk("setclr_irq", 32'(ir), 32'h1);
    bus(0, 2'b10, 32'hC, 32'h0, rd, g, ir);
    chk("setclr_pend", rd, 32'h01);

    rst = 1; ce = 1; req = 1; we = 1; hb = 2'b10; addr = 32'h0; wdata = 32'h3C;
    tick();
    rst = 0; ce = 0; req = 0;
    @(negedge clk);
    chk("rstmid_gnt",  32'(gnt),      32'h0);
    chk("rstmid_gpio", 32'(gpio_out), 32'h0);
    tick();
    bus(0, 2'b10, 32'h0, 32'h0, rd, g, ir);
    chk("rstmid_out", rd, 32'h0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
